muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu (range 1..15).
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage multiply/divide-class instruction valid this cycle.
REQ-006 SHALL have port op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo; 6 and 7 reserved.
REQ-007 SHALL have port rs_val  input  32  first operand, or the mthi/mtlo source.
REQ-008 SHALL have port rt_val  input  32  second operand.
REQ-009 SHALL have port md_req  input  1  D-stage holds any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1  freeze D-stage request to the hazard unit.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MULT and DIV; busy=1 exactly in MULT or DIV.
REQ-015 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored without changing state, hi or lo.
REQ-016 In IDLE, start with op 0/1 SHALL latch operands, load the 4-bit counter with MULT_CYC and enter MULT on the next edge.
REQ-017 In IDLE, start with op 2/3 SHALL latch operands, load the counter with DIV_CYC and enter DIV on the next edge.
REQ-018 In MULT/DIV, the counter SHALL decrement each cycle; on the edge where counter=1, the FSM SHALL commit the result to hi/lo and return to IDLE.
REQ-019 Cycle timing for start in cycle 0: busy=1 in cycles 1..N (N=MULT_CYC or DIV_CYC); the new hi/lo and busy=0 are visible in cycle N+1.
REQ-020 mult/multu SHALL produce a 64-bit signed/unsigned product; hi = bits 63:32, lo = bits 31:0.
REQ-021 div/divu SHALL give lo = quotient truncated toward zero and hi = remainder, with the remainder taking the sign of the dividend for div.
REQ-022 div with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-023 Divide by zero SHALL still hold busy for DIV_CYC cycles and SHALL leave hi and lo unchanged.
REQ-024 In IDLE, mthi/mtlo SHALL write rs_val to hi/lo on the next edge, with busy staying 0 and the other register unchanged.
REQ-025 Reserved op codes SHALL act as no-ops.
REQ-026 stall SHALL equal md_req AND (busy OR (start AND op in 0..3)), computed combinationally.
REQ-027 A start accepted on the same edge as a commit SHALL be impossible, because start is sampled only in IDLE; back-to-back operations SHALL start no earlier than cycle N+1.

Reset
REQ-028 Assertion of reset (reset=0) SHALL immediately force IDLE, counter=0, busy=0, hi=0 and lo=0, regardless of clk.
REQ-029 Reset mid-operation SHALL abort the operation, with no partial commit.
REQ-030 After deassertion, the first rising edge SHALL be able to accept start.

Configuration
REQ-031 With macro MULDIV_DIV_EN defined, div/divu SHALL behave per REQ-017 and REQ-021 to REQ-023.
REQ-032 With MULDIV_DIV_EN undefined, the divider logic SHALL be omitted and op 2/3 SHALL be no-ops (no busy, no stall contribution, hi/lo unchanged).

Verification
REQ-033 Reset, then mult with rs=0xFFFFFFFF and rt=2 -> busy high cycles 1..5; in cycle 6 hi=0xFFFFFFFF and lo=0xFFFFFFFE.
REQ-034 multu with rs=0xFFFFFFFF and rt=2 -> in cycle 6 hi=0x00000001 and lo=0xFFFFFFFE.
REQ-035 div with rs=0xFFFFFFF9 (-7) and rt=2 -> busy cycles 1..10; in cycle 11 lo=0xFFFFFFFD and hi=0xFFFFFFFF; also div by 0 -> hi/lo unchanged after 10 busy cycles.
REQ-036 mthi with 0x12345678, then mtlo with 0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0, busy never high.
REQ-037 md_req=1 during cycles 0..5 of a mult -> stall=1 in cycles 0..5 and 0 in cycle 6; a second start in cycle 3 is ignored.
REQ-038 reset=0 pulsed in cycle 3 of a div -> busy=0, hi=0 and lo=0 immediately; no commit occurs in cycle 11.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide controller for a pipelined MIPS-style core.
// Multiply and divide run as fixed-latency operations (MULT_CYC / DIV_CYC busy
// cycles) and results are committed to HI/LO on the final busy edge. mthi/mtlo
// write directly while idle.
// Build option: define MULDIV_DIV_EN to include the divider; without it,
// div/divu (op 2/3) are treated as no-ops.
module muldiv_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod;
    logic        md_start;

    // 64-bit product of the latched operands, signed or unsigned
    always_comb begin
        if (sgn_q) begin
            prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        end else begin
            prod = {32'd0, a_q} * {32'd0, b_q};
        end
    end

`ifdef MULDIV_DIV_EN
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_mag = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
        q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
        r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
        quo   = (sgn_q && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (sgn_q && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end
`endif

    // Start decode feeding the hazard unit; only ops that will go busy count
    always_comb begin
        md_start = start && ((op == OP_MULT) || (op == OP_MULTU));
`ifdef MULDIV_DIV_EN
        if (start && ((op == OP_DIV) || (op == OP_DIVU))) begin
            md_start = 1'b1;
        end
`endif
    end

    assign busy  = (state_q != IDLE);
    assign stall = md_req && (busy || md_start);
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Next-state logic: accept work only in IDLE, count down, commit on count==1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op == OP_MULT);
                            cnt_d   = MULT_LD;
                            state_d = MULT;
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op == OP_DIV);
                            cnt_d   = DIV_LD;
                            state_d = DIV;
                        end
`endif
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            MULT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                end
            end
            DIV: begin
`ifdef MULDIV_DIV_EN
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    // Divide by zero burns the cycles but leaves HI/LO alone
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
`else
                state_d = IDLE;
                cnt_d   = 4'd0;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers; reset clears everything at once, aborting any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl. A table of directed
// vectors, hand-written corner sequences and a randomized run are all checked
// against a cycle-level reference model of the HI/LO behaviour.
module tb_muldiv_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int DIV_BUSY = DIV_EN ? DC : 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .md_req (md_req),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: architectural HI/LO plus the pending result of an op
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    int          m_busy_until = -1;
    bit          m_pend = 1'b0;
    int          m_pend_at = 0;
    logic [31:0] m_phi, m_plo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          ncyc;
        bit          keep;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic sched(input logic [31:0] h, input logic [31:0] l, input int n, input bit valid);
        m_busy_until = cyc + n;
        if (valid) begin
            m_pend    = 1'b1;
            m_pend_at = cyc + n;
            m_phi     = h;
            m_plo     = l;
        end
    endtask

    task automatic model_accept();
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(rs_val));
        sb = longint'($signed(rt_val));
        case (op)
            3'd0: begin
                sp = sa * sb;
                sched(sp[63:32], sp[31:0], MC, 1'b1);
            end
            3'd1: begin
                up = {32'd0, rs_val} * {32'd0, rt_val};
                sched(up[63:32], up[31:0], MC, 1'b1);
            end
            3'd2: if (DIV_EN) begin
                if (rt_val != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    sched(sr[31:0], sq[31:0], DC, 1'b1);
                end else begin
                    sched(32'd0, 32'd0, DC, 1'b0);
                end
            end
            3'd3: if (DIV_EN) begin
                if (rt_val != 32'd0) sched(rs_val % rt_val, rs_val / rt_val, DC, 1'b1);
                else sched(32'd0, 32'd0, DC, 1'b0);
            end
            3'd4: m_hi = rs_val;
            3'd5: m_lo = rs_val;
            default: ;
        endcase
    endtask

    // One clock cycle: compare at the falling edge, advance the model, cross the rising edge
    task automatic step(output logic b_s, output logic s_s, output logic [31:0] hi_s, output logic [31:0] lo_s);
        bit eb, es, md_op;
        @(negedge clk);
        eb    = (cyc <= m_busy_until);
        md_op = (op == 3'd0) || (op == 3'd1) || (DIV_EN && ((op == 3'd2) || (op == 3'd3)));
        es    = md_req && (eb || (start && md_op));
        chk("model_busy", 32'(busy), 32'(eb));
        chk("model_stall", 32'(stall), 32'(es));
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
        b_s  = busy;
        s_s  = stall;
        hi_s = hi;
        lo_s = lo;
        if (!eb && start) model_accept();
        if (m_pend && (cyc == m_pend_at)) begin
            m_hi   = m_phi;
            m_lo   = m_plo;
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Asynchronous reset pulse in the middle of a cycle
    task automatic rst_pulse();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_busy_until = -1;
        m_pend = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        b_s, s_s;
        logic [31:0] hi_s, lo_s, t_hi, t_lo, e_hi, e_lo;
        bit          eb;

        // Directed vectors: {op, rs, rt, busy cycles, keep hi/lo, hi, lo}
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd2, MC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2, MC, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2, DIV_BUSY, !DIV_EN, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd2, 32'h1234_5678, 32'd0, DIV_BUSY, 1'b1, 32'd0, 32'd0};
        vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_BUSY, !DIV_EN, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, DIV_BUSY, !DIV_EN, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[6]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, MC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[7]  = '{3'd2, 32'd7, 32'hFFFF_FFFE, DIV_BUSY, !DIV_EN, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8]  = '{3'd1, 32'h0001_0000, 32'h0001_0000, MC, 1'b0, 32'h0000_0001, 32'h0000_0000};
        vecs[9]  = '{3'd6, 32'hDEAD_BEEF, 32'd3, 0, 1'b1, 32'd0, 32'd0};
        vecs[10] = '{3'd7, 32'hDEAD_BEEF, 32'd3, 0, 1'b1, 32'd0, 32'd0};

        reset  = 1'b0;
        start  = 1'b0;
        op     = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        md_req = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // mthi then mtlo back to back; busy must never rise
        start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678;
        step(b_s, s_s, hi_s, lo_s);
        chk("mthi_busy", 32'(b_s), 32'd0);
        op = 3'd5; rs_val = 32'h9ABC_DEF0;
        step(b_s, s_s, hi_s, lo_s);
        chk("mtlo_busy", 32'(b_s), 32'd0);
        start = 1'b0;
        step(b_s, s_s, hi_s, lo_s);
        chk("mt_busy", 32'(b_s), 32'd0);
        chk("mt_hi", hi_s, 32'h1234_5678);
        chk("mt_lo", lo_s, 32'h9ABC_DEF0);
        t_hi = 32'h1234_5678;
        t_lo = 32'h9ABC_DEF0;

        // Table-driven vectors: busy window and committed HI/LO
        for (int v = 0; v < 11; v++) begin
            start = 1'b1; op = vecs[v].op; rs_val = vecs[v].rs; rt_val = vecs[v].rt;
            step(b_s, s_s, hi_s, lo_s);
            chk($sformatf("vec%0d_busy0", v), 32'(b_s), 32'd0);
            start = 1'b0;
            e_hi = vecs[v].keep ? t_hi : vecs[v].ehi;
            e_lo = vecs[v].keep ? t_lo : vecs[v].elo;
            for (int k = 1; k <= vecs[v].ncyc + 1; k++) begin
                step(b_s, s_s, hi_s, lo_s);
                eb = (k <= vecs[v].ncyc);
                chk($sformatf("vec%0d_busy%0d", v, k), 32'(b_s), 32'(eb));
                if (k == vecs[v].ncyc + 1) begin
                    chk($sformatf("vec%0d_hi", v), hi_s, e_hi);
                    chk($sformatf("vec%0d_lo", v), lo_s, e_lo);
                end
            end
            t_hi = e_hi;
            t_lo = e_lo;
            $display("vector %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h", v, vecs[v].op, vecs[v].rs, vecs[v].rt, hi_s, lo_s);
        end

        // Stall during a mult; a second start (mthi) in cycle 3 must be ignored
        md_req = 1'b1;
        start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
        for (int k = 0; k <= 6; k++) begin
            if (k == 3) begin
                start = 1'b1; op = 3'd4; rs_val = 32'hDEAD_BEEF;
            end else if (k != 0) begin
                start = 1'b0;
            end
            step(b_s, s_s, hi_s, lo_s);
            chk($sformatf("stall_c%0d", k), 32'(s_s), (k <= 5) ? 32'd1 : 32'd0);
        end
        chk("stall_hi", hi_s, 32'd0);
        chk("stall_lo", lo_s, 32'd12);
        md_req = 1'b0;
        $display("stall sequence: hi=%h lo=%h", hi_s, lo_s);

        // Reset pulsed in cycle 3 of a divide: no commit afterwards
        start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        step(b_s, s_s, hi_s, lo_s);
        start = 1'b0;
        step(b_s, s_s, hi_s, lo_s);
        step(b_s, s_s, hi_s, lo_s);
        rst_pulse();
        for (int k = 3; k <= 12; k++) step(b_s, s_s, hi_s, lo_s);
        chk("abort_busy", 32'(b_s), 32'd0);
        chk("abort_hi", hi_s, 32'd0);
        chk("abort_lo", lo_s, 32'd0);
        $display("reset abort: hi=%h lo=%h", hi_s, lo_s);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            op     = 3'($urandom_range(0, 7));
            rs_val = pick();
            rt_val = pick();
            md_req = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) rst_pulse();
            step(b_s, s_s, hi_s, lo_s);
        end
        start  = 1'b0;
        md_req = 1'b0;
        for (int k = 0; k < DC + 2; k++) step(b_s, s_s, hi_s, lo_s);
        $display("random run done: hi=%h lo=%h", hi_s, lo_s);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
